// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target controller: FSM state encoding and
// the width of the optional bus-stuck timeout counter.
package i2c_pkg;

    localparam int TIMEOUT_W = 16;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT_STOP = 4'd9
    } ctrl_state_t;

endpackage

// File: rtl/bus_timeout.sv
// Bus-stuck watchdog: counts busy cycles since the last SCL edge and flags
// expiry on the TIMEOUT_CYCLES-th such cycle. Only built with BUS_TIMEOUT_EN.
module bus_timeout
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clock,
    input  logic reset,
    input  logic scl_edge,
    input  logic busy,
    output logic expired
);

    logic [TIMEOUT_W-1:0] cnt_q;

    // Restart on any SCL activity, when the bus is idle, or once it fires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (scl_edge || !busy || expired)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

    assign expired = busy && (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/i2c_target_ctrl.sv
// I2C target control FSM: sequences address, pointer, write and read phases
// and drives the datapath strobes. Optional feature macro: BUS_TIMEOUT_EN
// (adds the bus_timeout watchdog and the sticky timeout output).
module i2c_target_ctrl
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_posedge,
    input  logic       scl_negedge,
    input  logic       start,
    input  logic       stop,
    input  logic       bit_done,
    input  logic       addr_valid,
    input  logic       rw_bit,
    input  logic       master_ack,
    output logic       clear_start,
    output logic       clear_stop,
    output logic       cnt_clear,
    output logic       cnt_en,
    output logic       shift_en,
    output logic       sel_load,
    output logic       sel_inc,
    output logic       mem_we,
    output logic       send_ack,
    output logic       out_en,
    output logic       busy,
    output logic [3:0] state
`ifdef BUS_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);

    ctrl_state_t state_q, state_d;
    logic        ack_q, ack_d;
    logic        timeout_hit;

    assign busy  = (state_q != IDLE);
    assign state = state_q;

`ifdef BUS_TIMEOUT_EN
    logic timeout_q;

    bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_bus_timeout (
        .clock   (clock),
        .reset   (reset),
        .scl_edge(scl_posedge | scl_negedge),
        .busy    (busy),
        .expired (timeout_hit)
    );

    // Sticky stuck-bus flag; a fresh START acknowledges it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            timeout_q <= 1'b0;
        else if (start)
            timeout_q <= 1'b0;
        else if (timeout_hit)
            timeout_q <= 1'b1;
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_W'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
`endif

    // State and latched master ACK; reset drops straight to IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // Next state plus strobes: levels decode from state, pulses from SCL events.
    always_comb begin
        state_d     = state_q;
        ack_d       = ack_q;
        clear_start = 1'b0;
        clear_stop  = 1'b0;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        shift_en    = 1'b0;
        sel_load    = 1'b0;
        sel_inc     = 1'b0;
        mem_we      = 1'b0;
        send_ack    = 1'b0;
        out_en      = 1'b0;

        case (state_q)
            ADDR, PTR, WDATA: begin
                shift_en = 1'b1;
                cnt_en   = 1'b1;
            end
            ADDR_ACK: send_ack = 1'b1;
            PTR_ACK: begin
                send_ack = 1'b1;
                sel_load = 1'b1;
            end
            WDATA_ACK: begin
                send_ack = 1'b1;
                mem_we   = 1'b1;
                sel_inc  = 1'b1;
            end
            RDATA: begin
                cnt_en = 1'b1;
                // Release SDA as soon as the last bit's low phase begins.
                out_en = !(scl_negedge && bit_done);
            end
            default: ;
        endcase

        if (start) begin
            state_d     = ADDR;
            clear_start = 1'b1;
            clear_stop  = stop;
            cnt_clear   = 1'b1;
        end else if (timeout_hit) begin
            state_d     = IDLE;
            clear_start = 1'b1;
            clear_stop  = 1'b1;
            cnt_clear   = 1'b1;
        end else if (stop && state_q != IDLE) begin
            state_d    = IDLE;
            clear_stop = 1'b1;
            cnt_clear  = 1'b1;
        end else begin
            case (state_q)
                ADDR: if (scl_negedge && bit_done)
                    state_d = addr_valid ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: if (scl_negedge) begin
                    cnt_clear = 1'b1;
                    state_d   = rw_bit ? RDATA : PTR;
                end
                PTR: if (scl_negedge && bit_done)
                    state_d = PTR_ACK;
                PTR_ACK: if (scl_negedge) begin
                    cnt_clear = 1'b1;
                    state_d   = WDATA;
                end
                WDATA: if (scl_negedge && bit_done)
                    state_d = WDATA_ACK;
                WDATA_ACK: if (scl_negedge) begin
                    cnt_clear = 1'b1;
                    state_d   = WDATA;
                end
                RDATA: if (scl_negedge && bit_done)
                    state_d = RDATA_ACK;
                RDATA_ACK: begin
                    if (scl_posedge)
                        ack_d = master_ack;
                    if (scl_negedge) begin
                        sel_inc = 1'b1;
                        if (ack_q) begin
                            cnt_clear = 1'b1;
                            state_d   = RDATA;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (reset) begin
            clear_start = 1'b1;
            clear_stop  = 1'b1;
            cnt_clear   = 1'b1;
        end
    end

endmodule
